// File: rtl/upper_stream_ctrl.sv
// Byte-stream upper-caser: converts 'a'..'z' on entry, buffers in a 4-deep FIFO.
// Define UPPER_CNT_EN to add the saturating conv_count output.
module upper_stream_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
`ifdef UPPER_CNT_EN
  output logic        busy,
  output logic [15:0] conv_count
`else
  output logic        busy
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  count;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [8:0]  mem [4];
  logic [8:0]  head;
  logic        push;
  logic        pop;
  logic        is_lower;
  logic [7:0]  conv;

  assign is_lower  = (in_data >= 8'd97) && (in_data <= 8'd122);
  assign conv      = is_lower ? (in_data - 8'd32) : in_data;
  assign head      = mem[rd_ptr];
  assign in_ready  = (state != FLUSH) && (count < 3'd4);
  assign out_valid = (count != 3'd0);
  assign out_data  = out_valid ? head[7:0] : 8'h00;
  assign out_last  = out_valid & head[8];
  assign busy      = (state != IDLE);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage needs no reset: the head is masked while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_last, conv};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 3'd0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
    end else begin
      state <= state_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (push) begin
          state_nxt = in_last ? FLUSH : ACTIVE;
        end
      end
      ACTIVE: begin
        if (push && in_last) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (pop && head[8]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UPPER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_count <= 16'd0;
    end else if (push && is_lower && (conv_count != 16'hFFFF)) begin
      conv_count <= conv_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_upper_stream_ctrl.sv
// Scoreboard bench for upper_stream_ctrl; expected bytes queued on accept.
// Define UPPER_CNT_EN to also exercise conv_count.
module tb_upper_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
`ifdef UPPER_CNT_EN
  logic [15:0] conv_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q [$];

  upper_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef UPPER_CNT_EN
    .busy      (busy),
    .conv_count(conv_count)
`else
    .busy      (busy)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] upc(input logic [7:0] d);
    if (d >= 8'd97 && d <= 8'd122) return d - 8'd32;
    return d;
  endfunction

  // Output monitor: every handshake must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out: got data=%0d last=%0d, queue empty",
                 out_data, out_last);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          failures++;
          $display("FAIL out_byte: got data=%0d last=%0d, want data=%0d last=%0d",
                   out_data, out_last, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%0d, want 1 for byte %0d", in_ready, d);
    end else begin
      exp_q.push_back({l, upc(d)});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d bytes outstanding, want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    @(posedge clk);
    pulse_reset();
    @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_out_valid: got %0d want 0", out_valid);
    end
    if (out_data !== 8'h00) begin
      failures++; $display("FAIL rst_out_data: got %0d want 0", out_data);
    end
    if (out_last !== 1'b0) begin
      failures++; $display("FAIL rst_out_last: got %0d want 0", out_last);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy: got %0d want 0", busy);
    end
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready: got %0d want 1", in_ready);
    end
`ifdef UPPER_CNT_EN
    checks++;
    if (conv_count !== 16'd0) begin
      failures++; $display("FAIL rst_conv_count: got %0d want 0", conv_count);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame();
    out_ready = 1'b1;
    send(8'd97, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL frame_busy: got %0d want 1", busy);
    end
    @(posedge clk);
    #1;
    send(8'd90, 1'b0);
    send(8'd123, 1'b1);
    drain();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL frame_busy_end: got %0d want 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] d [4] = '{8'd97, 8'd98, 8'd99, 8'd100};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(d[i], 1'b0);
    end
    @(negedge clk);
    checks += 3;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL full_in_ready: got %0d want 0", in_ready);
    end
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL full_out_valid: got %0d want 1", out_valid);
    end
    if (out_data !== 8'd65) begin
      failures++; $display("FAIL full_head: got %0d want 65", out_data);
    end
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'd101, 1'b1);
    drain();
  endtask

  task automatic test_passthrough();
    logic [7:0] d [7] = '{8'd40, 8'd96, 8'd123, 8'd131, 8'd183, 8'd235, 8'd127};
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(d[i], i == 6);
    end
    drain();
`ifdef UPPER_CNT_EN
    checks++;
    if (conv_count !== 16'd0) begin
      failures++; $display("FAIL pass_conv_count: got %0d want 0", conv_count);
    end
`endif
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    send(8'd109, 1'b1);
    @(negedge clk);
    checks += 4;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL single_busy: got %0d want 1", busy);
    end
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL single_in_ready: got %0d want 0", in_ready);
    end
    if (out_data !== 8'd77) begin
      failures++; $display("FAIL single_data: got %0d want 77", out_data);
    end
    if (out_last !== 1'b1) begin
      failures++; $display("FAIL single_last: got %0d want 1", out_last);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL single_idle: got %0d want 0", busy);
    end
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL single_ready_end: got %0d want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b0;
    send(8'd97, 1'b0);
    send(8'd98, 1'b0);
    pulse_reset();
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_out_valid: got %0d want 0", out_valid);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL midrst_busy: got %0d want 0", busy);
    end
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_in_ready: got %0d want 1", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'd122, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    fork
      begin
        for (int f = 0; f < 4; f++) begin
          int len = $urandom_range(1, 5);
          for (int i = 0; i < len; i++) begin
            send(8'($urandom_range(0, 255)), i == len - 1);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

`ifdef UPPER_CNT_EN
  task automatic test_saturate();
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      send(8'd97, i == 69999);
      if (i == 999) begin
        checks++;
        if (conv_count !== 16'd1000) begin
          failures++; $display("FAIL cnt_1000: got %0d want 1000", conv_count);
        end
      end
    end
    drain();
    checks++;
    if (conv_count !== 16'hFFFF) begin
      failures++; $display("FAIL cnt_sat: got %0d want 65535", conv_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_passthrough();
    test_single();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef UPPER_CNT_EN
    test_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
